seg_scan_flash_ctrl: RTL and testbench

//  Time-multiplexed 7-segment driver for the clock/alarm display, the next generation of the
//  per-field flashing display stage. Accepts NUM_DIGITS BCD/hex nibbles and scans them onto one

---
 rtl/disp_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 31 +++
 rtl/seg_scan_flash_ctrl.sv | 91 +++++++++
 tb/tb_seg_scan_flash_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display constants: 7-segment codes ({g,f,e,d,c,b,a}, active-high) and field indices.
package disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int FIELD_SEC  = 0;
  localparam int FIELD_MIN  = 1;
  localparam int FIELD_HOUR = 2;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to 7-segment code.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_flash_ctrl.sv
// Multiplexed 7-segment scanner with per-field blink and per-digit blanking.
module seg_scan_flash_ctrl
  import disp_pkg::*;
#(
  parameter  int NUM_DIGITS       = 6,
  parameter  int DIGITS_PER_FIELD = 2,
  parameter  int SCAN_DIV         = 1000,
  parameter  int FLASH_DIV        = 250000,
  localparam int NUM_FIELDS       = NUM_DIGITS / DIGITS_PER_FIELD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_FIELDS-1:0]   field_sel,
  input  logic                    flash_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic                    flash_phase
);

  localparam int SCW = $clog2(SCAN_DIV);
  localparam int FCW = $clog2(FLASH_DIV);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
  localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [SCW-1:0] scan_cnt;
  logic [IW-1:0]  scan_idx;
  logic [FCW-1:0] flash_cnt;

  logic [NUM_DIGITS-1:0][3:0] dig_arr;
  logic [NUM_DIGITS-1:0]      fsel_dig;
  logic [3:0]                 nibble;
  logic [6:0]                 seg_code;
  logic                       dark;

  assign dig_arr = digits_in;

  // Fan each field's select bit out to its digits so the slot lookup is a plain index.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_fsel
    assign fsel_dig[d] = field_sel[d / DIGITS_PER_FIELD];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SCW'(1);
    end
  end

  // Holding the timer clear while disabled guarantees a full "on" half after re-enable.
  always_ff @(posedge clk) begin
    if (!rst_n || !flash_en) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (flash_cnt == FLASH_LAST) begin
      flash_cnt   <= '0;
      flash_phase <= ~flash_phase;
    end else begin
      flash_cnt <= flash_cnt + FCW'(1);
    end
  end

  assign nibble = dig_arr[scan_idx];
  assign dark   = blank_mask[scan_idx] | (fsel_dig[scan_idx] & flash_phase);

  seg7_decode u_dec (
    .nib (nibble),
    .seg (seg_code)
  );

  // Dark digits keep their select asserted so every slot gets the same duty cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg       <= SEG_BLANK;
      dig_sel_n <= '1;
    end else begin
      seg       <= dark ? SEG_BLANK : seg_code;
      dig_sel_n <= ~(NUM_DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: tb/tb_seg_scan_flash_ctrl.sv
// Randomized bench for seg_scan_flash_ctrl against an arithmetic reference model.
module tb_seg_scan_flash_ctrl;

  localparam int ND  = 6;
  localparam int DPF = 2;
  localparam int SD  = 4;
  localparam int FD  = 8;
  localparam int NF  = ND / DPF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4*ND-1:0] digits_in;
  logic [ND-1:0]   blank_mask;
  logic [NF-1:0]   field_sel;
  logic            flash_en;
  logic [6:0]      seg;
  logic [ND-1:0]   dig_sel_n;
  logic            flash_phase;

  int total = 0;
  int bad   = 0;

  // Model state: edges since reset release, and consecutive enabled-flash edges.
  int k   = 0;
  int run = 0;

  logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_flash_ctrl #(
    .NUM_DIGITS       (ND),
    .DIGITS_PER_FIELD (DPF),
    .SCAN_DIV         (SD),
    .FLASH_DIV        (FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digits_in),
    .blank_mask  (blank_mask),
    .field_sel   (field_sel),
    .flash_en    (flash_en),
    .seg         (seg),
    .dig_sel_n   (dig_sel_n),
    .flash_phase (flash_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already driven; predicts the next edge and checks it.
  task automatic step();
    int         idx, ph;
    logic [3:0] nib;
    logic       dark;
    logic [6:0] es;
    logic [5:0] esel;
    logic       eph;
    if (!rst_n) begin
      es = 7'h00; esel = 6'h3F; eph = 1'b0;
      k = 0; run = 0;
    end else begin
      idx  = (k / SD) % ND;
      ph   = (run / FD) % 2;
      nib  = 4'((digits_in >> (4 * idx)) & 24'hF);
      dark = blank_mask[idx] | (field_sel[idx / DPF] & (ph == 1));
      es   = dark ? 7'h00 : segtab[nib];
      esel = ~(6'b000001 << idx);
      k++;
      if (flash_en) begin
        run++;
        eph = ((run / FD) % 2) == 1;
      end else begin
        run = 0;
        eph = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("seg", 32'(seg), 32'(es));
    chk("dig_sel_n", 32'(dig_sel_n), 32'(esel));
    chk("flash_phase", 32'(flash_phase), 32'(eph));
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; digits_in = '0; blank_mask = '0; field_sel = '0; flash_en = 1'b0;
    @(negedge clk);

    // Reset held, then release: first slot selects digit 0.
    steps(3);
    rst_n = 1'b1;
    digits_in = 24'h123456;
    step();
    chk("first_sel", 32'(dig_sel_n), 32'h3E);

    // Plain scan, more than one full wrap.
    steps(30);

    // Blink minutes field on all-8s display.
    digits_in = 24'h888888;
    field_sel = 3'b010;
    flash_en  = 1'b1;
    steps(12);
    chk("mid_off_phase", 32'(flash_phase), 32'h1);
    // Drop flash while in the off half, then re-enable.
    flash_en = 1'b0;
    steps(10);
    flash_en = 1'b1;
    steps(40);

    // Blank the leftmost digit.
    flash_en   = 1'b0;
    field_sel  = '0;
    digits_in  = 24'h012345;
    blank_mask = 6'b100000;
    steps(30);

    // Reset in the middle of an off half with scanning in progress.
    blank_mask = '0;
    field_sel  = 3'b111;
    flash_en   = 1'b1;
    steps(25);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    steps(10);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) digits_in = 24'($urandom);
      if ($urandom_range(0, 15) == 0) blank_mask = 6'($urandom);
      if ($urandom_range(0, 15) == 0) field_sel = 3'($urandom);
      if ($urandom_range(0, 31) == 0) flash_en = ~flash_en;
      rst_n = ($urandom_range(0, 127) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
